// File: rtl/smmha_tcdm_arbiter_pkg.sv
// smmha_package: shared defaults and helpers for the TCDM arbiter slice.
package smmha_package;
   localparam int SMMHA_ARB_N_REQ   = 4;
   localparam int SMMHA_ARB_MAX_OUT = 4;
   localparam int SMMHA_ARB_AW      = 32;
   localparam int SMMHA_ARB_DW      = 32;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/smmha_arb_id_fifo.sv
// smmha_arb_id_fifo: in-order FIFO of requester indices for outstanding reads.
module smmha_arb_id_fifo
   import smmha_package::*;
#(
   parameter int DEPTH = SMMHA_ARB_MAX_OUT,
   parameter int W     = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] id_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int PW = $clog2(DEPTH);
   logic [PW:0] wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH-1:0][W-1:0] mem_q;
   logic do_push, do_pop;
   // Extra pointer MSB distinguishes full from empty.
   assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign head_o  = mem_q[rd_q[PW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
   assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push) mem_q[wr_q[PW-1:0]] <= id_i;
      end
   end
endmodule

// File: rtl/smmha_tcdm_arbiter.sv
// smmha_tcdm_arbiter: round-robin arbiter sharing one TCDM master port among
// N_REQ streamers, with in-order read-response routing.
module smmha_tcdm_arbiter
   import smmha_package::*;
#(
   parameter int N_REQ   = SMMHA_ARB_N_REQ,
   parameter int MAX_OUT = SMMHA_ARB_MAX_OUT,
   parameter int AW      = SMMHA_ARB_AW,
   parameter int DW      = SMMHA_ARB_DW
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_REQ-1:0]               req_i,
   output logic [N_REQ-1:0]               gnt_o,
   input  logic [N_REQ-1:0][AW-1:0]       add_i,
   input  logic [N_REQ-1:0]               wen_i,
   input  logic [N_REQ-1:0][DW/8-1:0]     be_i,
   input  logic [N_REQ-1:0][DW-1:0]       data_i,
   output logic [N_REQ-1:0][DW-1:0]       r_data_o,
   output logic [N_REQ-1:0]               r_valid_o,
   output logic                           mst_req_o,
   output logic [AW-1:0]                  mst_add_o,
   output logic                           mst_wen_o,
   output logic [DW/8-1:0]                mst_be_o,
   output logic [DW-1:0]                  mst_data_o,
   input  logic                           mst_gnt_i,
   input  logic [DW-1:0]                  mst_r_data_i,
   input  logic                           mst_r_valid_i,
   output logic                           busy_o
);
   localparam int IW = idx_w(N_REQ);
   logic [IW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, win, head;
   logic lock_q, lock_d, found, full, empty, xfer, push, pop;
   int k;
   // A held lock wins only while its requester keeps req_i high.
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      k     = 0;
      if (lock_q && req_i[lock_idx_q]) begin
         win   = lock_idx_q;
         found = 1'b1;
      end else begin
         for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(ptr_q) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (req_i[IW'(k)]) begin
               win   = IW'(k);
               found = 1'b1;
            end
         end
      end
   end
   assign mst_req_o  = !rst_i && found && !full;
   assign mst_add_o  = rst_i ? '0 : add_i[win];
   assign mst_wen_o  = rst_i ? 1'b0 : wen_i[win];
   assign mst_be_o   = rst_i ? '0 : be_i[win];
   assign mst_data_o = rst_i ? '0 : data_i[win];
   assign xfer       = mst_req_o && mst_gnt_i;
   assign push       = xfer && mst_wen_o;
   assign pop        = !rst_i && mst_r_valid_i && !empty;
   assign busy_o     = !empty || mst_req_o;
   always_comb begin
      gnt_o     = '0;
      r_valid_o = '0;
      if (xfer) gnt_o[win] = 1'b1;
      if (pop) r_valid_o[head] = 1'b1;
      for (int i = 0; i < N_REQ; i++) r_data_o[i] = rst_i ? '0 : mst_r_data_i;
   end
   always_comb begin
      ptr_d      = xfer ? ((win == IW'(N_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
      lock_d     = mst_req_o && !mst_gnt_i;
      lock_idx_d = lock_d ? win : lock_idx_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end
   smmha_arb_id_fifo #(
      .DEPTH(MAX_OUT),
      .W    (IW)
   ) u_id_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push),
      .pop_i  (pop),
      .id_i   (win),
      .full_o (full),
      .empty_o(empty),
      .head_o (head)
   );
endmodule

// File: tb/tb_smmha_tcdm_arbiter.sv
// tb_smmha_tcdm_arbiter: directed stimulus with a queue scoreboard; a negedge
// monitor checks every grant and every read response in order.
module tb_smmha_tcdm_arbiter;
   logic clk = 1'b0;
   logic rst_i;
   logic [3:0] req_i, gnt_o, wen_i, r_valid_o;
   logic [3:0][31:0] add_i, data_i, r_data_o;
   logic [3:0][3:0] be_i;
   logic mst_req_o, mst_wen_o, mst_gnt_i, mst_r_valid_i, busy_o;
   logic [31:0] mst_add_o, mst_data_o, mst_r_data_i;
   logic [3:0] mst_be_o;
   int vectors = 0, miscompares = 0;
   int exp_gnt[$], exp_rsp[$];
   int g, h;
   always #5 clk = ~clk;
   smmha_tcdm_arbiter dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
      .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o),
      .r_valid_o(r_valid_o), .mst_req_o(mst_req_o), .mst_add_o(mst_add_o),
      .mst_wen_o(mst_wen_o), .mst_be_o(mst_be_o), .mst_data_o(mst_data_o),
      .mst_gnt_i(mst_gnt_i), .mst_r_data_i(mst_r_data_i),
      .mst_r_valid_i(mst_r_valid_i), .busy_o(busy_o)
   );
   function automatic logic [31:0] addr(input int i);
      return 32'h1000 + 32'(i) * 32'h10;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (!rst_i) begin
         if (gnt_o != 4'b0) begin
            if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'(gnt_o), 64'h0);
            else begin
               g = exp_gnt.pop_front();
               chk("gnt", 64'(gnt_o), 64'(4'b1 << g));
               chk("gnt_add", 64'(mst_add_o), 64'(addr(g)));
            end
         end
         if (r_valid_o != 4'b0) begin
            if (exp_rsp.size() == 0) chk("unexpected_rvalid", 64'(r_valid_o), 64'h0);
            else begin
               h = exp_rsp.pop_front();
               chk("rvalid", 64'(r_valid_o), 64'(4'b1 << h));
               chk("r_data", 64'(r_data_o[h]), 64'(mst_r_data_i));
            end
         end
      end
   end
   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 4; i++) begin
         add_i[i]  = addr(i);
         data_i[i] = 32'hCAFE_0000 + 32'(i);
         be_i[i]   = 4'hF;
      end
      rst_i = 1'b1; req_i = 4'hF; wen_i = 4'hF; mst_gnt_i = 1'b1;
      mst_r_valid_i = 1'b1; mst_r_data_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rst_mst_req", 64'(mst_req_o), 64'h0);
      chk("rst_gnt", 64'(gnt_o), 64'h0);
      chk("rst_rvalid", 64'(r_valid_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_rdata", 64'(r_data_o[0]), 64'h0);
      step;
      rst_i = 1'b0; req_i = 4'h0; mst_r_valid_i = 1'b0; mst_gnt_i = 1'b0;
      step;
      // writes only, all requesting: grants 0,1,2,3,0
      wen_i = 4'h0; mst_gnt_i = 1'b1;
      exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
      exp_gnt.push_back(3); exp_gnt.push_back(0);
      req_i = 4'hF;
      repeat (5) @(posedge clk);
      #1;
      exp_gnt.push_back(3); req_i = 4'b1000;
      step;
      // ptr = 0: requester 2 pending, then requester 0 rises
      req_i = 4'b0100; mst_gnt_i = 1'b0;
      @(negedge clk);
      chk("lock_req", 64'(mst_req_o), 64'h1);
      chk("lock_add", 64'(mst_add_o), 64'(addr(2)));
      step;
      req_i = 4'b0101;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("lock_hold_add", 64'(mst_add_o), 64'(addr(2)));
         chk("lock_hold_gnt", 64'(gnt_o), 64'h0);
         step;
      end
      exp_gnt.push_back(2); mst_gnt_i = 1'b1;
      step;
      req_i = 4'hF; mst_gnt_i = 1'b0;
      @(negedge clk);
      chk("ptr_after_lock", 64'(mst_add_o), 64'(addr(3)));
      step;
      req_i = 4'h0;
      step;
      // reads from 1,3,1,0 fill the ID FIFO
      wen_i = 4'hF; mst_gnt_i = 1'b1;
      foreach (exp_rsp[i]) chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
      begin
         int rd [4] = '{1, 3, 1, 0};
         foreach (rd[i]) begin
            exp_gnt.push_back(rd[i]); exp_rsp.push_back(rd[i]);
            req_i = 4'b1 << rd[i];
            step;
         end
      end
      req_i = 4'b0100;
      @(negedge clk);
      chk("stall_mst_req", 64'(mst_req_o), 64'h0);
      chk("stall_gnt", 64'(gnt_o), 64'h0);
      chk("stall_busy", 64'(busy_o), 64'h1);
      step;
      mst_r_valid_i = 1'b1; mst_r_data_i = 32'h0000_00A0;
      @(negedge clk);
      chk("no_bypass", 64'(mst_req_o), 64'h0);
      chk("first_rvalid", 64'(r_valid_o), 64'h2);
      exp_gnt.push_back(2); exp_rsp.push_back(2);
      step;
      mst_r_valid_i = 1'b0;
      step;
      req_i = 4'h0; mst_r_valid_i = 1'b1; mst_r_data_i = 32'h0000_00B1;
      step;
      mst_r_data_i = 32'h0000_00B2;
      step;
      // occupancy 2: push (requester 1) and pop (head 0) together
      mst_r_data_i = 32'h0000_00C1; req_i = 4'b0010;
      exp_gnt.push_back(1); exp_rsp.push_back(1);
      @(negedge clk);
      chk("pushpop_rvalid", 64'(r_valid_o), 64'h1);
      chk("pushpop_gnt", 64'(gnt_o), 64'h2);
      step;
      req_i = 4'h0; mst_r_data_i = 32'h0000_00C2;
      step;
      mst_r_data_i = 32'h0000_00C3;
      step;
      mst_r_data_i = 32'h0000_00C4;
      @(negedge clk);
      chk("empty_rvalid", 64'(r_valid_o), 64'h0);
      chk("empty_busy", 64'(busy_o), 64'h0);
      step;
      mst_r_valid_i = 1'b0;
      // three reads outstanding, then reset
      for (int r = 0; r < 3; r++) begin
         exp_gnt.push_back(r);
         req_i = 4'b1 << r;
         step;
      end
      req_i = 4'h0; mst_gnt_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 64'(busy_o), 64'h1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy_o), 64'h0);
      chk("mid_rst_mst_req", 64'(mst_req_o), 64'h0);
      step;
      rst_i = 1'b0; mst_r_valid_i = 1'b1; mst_r_data_i = 32'h0000_00D0;
      @(negedge clk);
      chk("late_rvalid", 64'(r_valid_o), 64'h0);
      chk("post_rst_busy", 64'(busy_o), 64'h0);
      step;
      mst_r_valid_i = 1'b0; req_i = 4'hF;
      @(negedge clk);
      chk("post_rst_ptr", 64'(mst_add_o), 64'(addr(0)));
      step;
      req_i = 4'h0;
      step;
      chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'h0);
      chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
